// File: rtl/byte_unstrip_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_unstrip_pkg : K-symbol constants and framing state encoding |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package byte_unstrip_pkg;

    // K-code symbols shared with the transmit-side striper
    localparam logic [7:0] c_K_STP = 8'hFB;
    localparam logic [7:0] c_K_SDP = 8'h5C;
    localparam logic [7:0] c_K_END = 8'hFD;
    localparam logic [7:0] c_K_EDB = 8'hFE;
    localparam logic [7:0] c_K_COM = 8'hBC;
    localparam logic [7:0] c_K_SKP = 8'h1C;
    localparam logic [7:0] c_K_IDL = 8'h7C;

    typedef enum logic [0:0] {
        FRAME_IDLE  = 1'b0,
        FRAME_INPKT = 1'b1
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_unstrip_frame_chk.sv
`default_nettype none
// +------------------------------------------------------------------+
// | unstrip_frame_chk : packet framing tracker on the rebuilt stream |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module unstrip_frame_chk
    import byte_unstrip_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS-1:0]   i_byte,
    input  logic              i_k,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_valid,
    output logic              o_pkt_active,
    output logic              o_frame_err
);

    frame_state_t r_state;
    frame_state_t w_state_nxt;
    logic         w_pa_nxt;
    logic         w_err_nxt;
    logic         w_start;
    logic         w_end;
    logic         w_lane_first;
    logic         w_lane_last;

    assign w_start      = i_k && ((i_byte == BITS'(c_K_STP)) || (i_byte == BITS'(c_K_SDP)));
    assign w_end        = i_k && ((i_byte == BITS'(c_K_END)) || (i_byte == BITS'(c_K_EDB)));
    assign w_lane_first = (i_lane == '0);
    assign w_lane_last  = (i_lane == '1);

    always_comb begin
        w_state_nxt = r_state;
        w_pa_nxt    = (r_state == FRAME_INPKT);
        w_err_nxt   = 1'b0;
        if (!i_valid) begin
            w_pa_nxt = 1'b0;
        end else begin
            case (r_state)
                FRAME_IDLE: begin
                    if (w_start) begin
                        if (w_lane_first) begin
                            w_state_nxt = FRAME_INPKT;
                            w_pa_nxt    = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (w_end) begin
                        w_err_nxt = 1'b1;
                    end
                end
                FRAME_INPKT: begin
                    // the closing symbol itself is still part of the packet
                    if (w_end) begin
                        w_state_nxt = FRAME_IDLE;
                        w_err_nxt   = !w_lane_last;
                    end else if (w_start) begin
                        w_err_nxt = 1'b1;
                        if (!w_lane_first) begin
                            w_state_nxt = FRAME_IDLE;
                        end
                    end
                end
                default: w_state_nxt = FRAME_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FRAME_IDLE;
            o_pkt_active <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            o_pkt_active <= w_pa_nxt;
            o_frame_err  <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_unstrip.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_unstrip : 4-lane word to byte serialiser with framing check |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module byte_unstrip
    import byte_unstrip_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] LANE0,
    input  logic [BITS-1:0] LANE1,
    input  logic [BITS-1:0] LANE2,
    input  logic [BITS-1:0] LANE3,
    input  logic [3:0]      LANE_DK,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [BITS-1:0] D,
    output logic            o_DK,
    output logic            OUT_VALID,
    output logic            PKT_ACTIVE,
    output logic            FRAME_ERR
);

    localparam int c_IDX_W = $clog2(LANES);

    logic [LANES-1:0][BITS-1:0] w_in_data;
    logic [LANES-1:0]           w_in_dk;
    logic [LANES-1:0][BITS-1:0] r_ser_data;
    logic [LANES-1:0]           r_ser_dk;
    logic                       r_ser_valid;
    logic [c_IDX_W-1:0]         r_idx;
    logic [LANES-1:0][BITS-1:0] r_hold_data;
    logic [LANES-1:0]           r_hold_dk;
    logic                       r_hold_valid;
    logic                       w_accept;
    logic                       w_ser_last;
    logic                       w_to_ser;
    logic [BITS-1:0]            w_cur_byte;
    logic                       w_cur_k;

    assign w_in_data  = {LANE3, LANE2, LANE1, LANE0};
    assign w_in_dk    = LANE_DK;
    assign IN_READY   = !r_hold_valid && !RESET;
    assign w_accept   = IN_VALID && IN_READY;
    assign w_ser_last = r_ser_valid && (r_idx == c_IDX_W'(LANES - 1));
    // HOLD is necessarily empty whenever a word is accepted
    assign w_to_ser   = !r_ser_valid || w_ser_last;
    assign w_cur_byte = r_ser_data[r_idx];
    assign w_cur_k    = r_ser_dk[r_idx];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ser_data   <= '0;
            r_ser_dk     <= '0;
            r_ser_valid  <= 1'b0;
            r_idx        <= '0;
            r_hold_data  <= '0;
            r_hold_dk    <= '0;
            r_hold_valid <= 1'b0;
            D            <= '0;
            o_DK         <= 1'b0;
            OUT_VALID    <= 1'b0;
        end else begin
            if (r_ser_valid) begin
                D         <= w_cur_byte;
                o_DK      <= w_cur_k;
                OUT_VALID <= 1'b1;
                r_idx     <= r_idx + 1'b1;
                if (w_ser_last) begin
                    if (r_hold_valid) begin
                        r_ser_data   <= r_hold_data;
                        r_ser_dk     <= r_hold_dk;
                        r_hold_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_ser_data <= w_in_data;
                        r_ser_dk   <= w_in_dk;
                    end else begin
                        r_ser_valid <= 1'b0;
                    end
                end
            end else begin
                OUT_VALID <= 1'b0;
                if (w_accept) begin
                    r_ser_data  <= w_in_data;
                    r_ser_dk    <= w_in_dk;
                    r_ser_valid <= 1'b1;
                    r_idx       <= '0;
                end
            end
            if (w_accept && !w_to_ser) begin
                r_hold_data  <= w_in_data;
                r_hold_dk    <= w_in_dk;
                r_hold_valid <= 1'b1;
            end
        end
    end

    unstrip_frame_chk #(
        .BITS   (BITS),
        .LANE_W (c_IDX_W)
    ) u_frame_chk (
        .clk          (CLK),
        .rst          (RESET),
        .i_byte       (w_cur_byte),
        .i_k          (w_cur_k),
        .i_lane       (r_idx),
        .i_valid      (r_ser_valid),
        .o_pkt_active (PKT_ACTIVE),
        .o_frame_err  (FRAME_ERR)
    );

endmodule
`default_nettype wire

// File: tb/tb_byte_unstrip.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_byte_unstrip : scoreboard bench for byte_unstrip              |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_byte_unstrip;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] LANE0, LANE1, LANE2, LANE3;
    logic [3:0] LANE_DK;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] D;
    logic       o_DK;
    logic       OUT_VALID;
    logic       PKT_ACTIVE;
    logic       FRAME_ERR;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       pa;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    byte_unstrip #(.LANES(4), .BITS(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LANE0      (LANE0),
        .LANE1      (LANE1),
        .LANE2      (LANE2),
        .LANE3      (LANE3),
        .LANE_DK    (LANE_DK),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .D          (D),
        .o_DK       (o_DK),
        .OUT_VALID  (OUT_VALID),
        .PKT_ACTIVE (PKT_ACTIVE),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // w[8*i +: 8] is lane i; pa/er give the expected flags per lane
    task automatic send_word(input logic [31:0] w, input logic [3:0] dk,
                             input logic [3:0] pa, input logic [3:0] er);
        int   n = 0;
        exp_t e;
        LANE0    = w[7:0];
        LANE1    = w[15:8];
        LANE2    = w[23:16];
        LANE3    = w[31:24];
        LANE_DK  = dk;
        IN_VALID = 1'b1;
        while (!IN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 0);
        for (int i = 0; i < 4; i++) begin
            e.d  = w[8*i +: 8];
            e.k  = dk[i];
            e.pa = pa[i];
            e.er = er[i];
            sb.push_back(e);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic measure_run(output int wait_n, output int len);
        wait_n = 0;
        len    = 0;
        while (!OUT_VALID && wait_n < 40) begin
            @(negedge CLK);
            wait_n++;
        end
        while (OUT_VALID && len < 40) begin
            len++;
            @(negedge CLK);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || OUT_VALID) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(n), 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (OUT_VALID) begin
            if (sb.size() == 0) begin
                check("unexpected_byte_qsize", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("byte_d",    {24'h0, D}, {24'h0, e.d});
                check("byte_k",    {31'h0, o_DK}, {31'h0, e.k});
                check("byte_pa",   {31'h0, PKT_ACTIVE}, {31'h0, e.pa});
                check("byte_err",  {31'h0, FRAME_ERR}, {31'h0, e.er});
            end
        end else begin
            check("idle_pa",  {31'h0, PKT_ACTIVE}, 0);
            check("idle_err", {31'h0, FRAME_ERR}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_n, len, lows, n;
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        LANE0 = 8'h00; LANE1 = 8'h00; LANE2 = 8'h00; LANE3 = 8'h00;
        LANE_DK = 4'h0;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", {31'h0, OUT_VALID}, 0);
        check("rst_d",         {24'h0, D}, 0);
        check("rst_dk",        {31'h0, o_DK}, 0);
        check("rst_in_ready",  {31'h0, IN_READY}, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rel_in_ready", {31'h0, IN_READY}, 1);

        // single word: latency and run length
        send_word(32'h3322_11FB, 4'b0001, 4'b1111, 4'b0000);
        check("t1_pre_valid", {31'h0, OUT_VALID}, 0);
        measure_run(wait_n, len);
        check("t1_wait", 32'(wait_n), 1);
        check("t1_len",  32'(len), 4);
        drain();

        // three back-to-back words, closed by FD on lane 3
        lows = 0;
        fork
            begin
                send_word(32'hA3A2_A1A0, 4'b0000, 4'b1111, 4'b0000);
                send_word(32'hB3B2_B1B0, 4'b0000, 4'b1111, 4'b0000);
                send_word(32'hFDC2_C1C0, 4'b1000, 4'b1111, 4'b0000);
            end
            begin
                measure_run(wait_n, len);
            end
            begin
                repeat (20) begin
                    if (!IN_READY) lows++;
                    @(negedge CLK);
                end
            end
        join
        check("t2_len",        32'(len), 12);
        check("t2_ready_lows", 32'(lows), 6);
        drain();

        // packet open, close, then non-packet K symbols
        send_word(32'h0302_01FB, 4'b0001, 4'b1111, 4'b0000);
        send_word(32'hFDCC_BBAA, 4'b1000, 4'b1111, 4'b0000);
        send_word(32'h007C_1CBC, 4'b0111, 4'b0000, 4'b0000);
        // misplaced END on lane 1
        send_word(32'h2221_20FB, 4'b0001, 4'b1111, 4'b0000);
        send_word(32'h1312_FD10, 4'b0010, 4'b0011, 4'b0010);
        // STP on lane 2 and EDB while idle
        send_word(32'h33FB_1100, 4'b0100, 4'b0000, 4'b0100);
        send_word(32'h0000_00FE, 4'b0001, 4'b0000, 4'b0001);
        // SDP on lane 0 inside a packet restarts it
        send_word(32'h0302_015C, 4'b0001, 4'b1111, 4'b0000);
        send_word(32'h0605_045C, 4'b0001, 4'b1111, 4'b0001);
        send_word(32'hFD00_0000, 4'b1000, 4'b1111, 4'b0000);
        drain();

        // reset once lane 1 has been emitted
        send_word(32'h4443_4241, 4'b0000, 4'b0000, 4'b0000);
        n = 0;
        while (sb.size() != 2 && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("t6_reach_lane1", 32'(sb.size()), 2);
        RESET = 1'b1;
        sb.delete();
        @(negedge CLK);
        check("t6_rst_valid",    {31'h0, OUT_VALID}, 0);
        check("t6_rst_d",        {24'h0, D}, 0);
        check("t6_rst_in_ready", {31'h0, IN_READY}, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("t6_rel_in_ready", {31'h0, IN_READY}, 1);
        check("t6_rel_valid",    {31'h0, OUT_VALID}, 0);
        @(negedge CLK);
        check("t6_no_tail",      {31'h0, OUT_VALID}, 0);

        // recovery after reset
        send_word(32'h5352_51FB, 4'b0001, 4'b1111, 4'b0000);
        send_word(32'hFE62_6160, 4'b1000, 4'b1111, 4'b0000);
        drain();
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_unstrip.md
Name: byte_unstrip

Overview:
Receive-side counterpart of the four-lane byte striper. It accepts one 4-lane symbol word per handshake and serialises it back into a single byte stream in lane order 0,1,2,3, with a per-byte K flag. A framing checker tracks STP/SDP…END/EDB packet boundaries on the rebuilt stream and flags lane-placement violations. It sits between the lane deskew logic and the link-layer receiver.

Parameters:
LANES, 4, number of lanes; ports are fixed at four, so only 4 is legal
BITS, 8, symbol width in bits

Ports:
CLK  in  1  single clock; all state changes on posedge
RESET  in  1  synchronous, active-high reset
LANE0  in  BITS  lane 0 symbol
LANE1  in  BITS  lane 1 symbol
LANE2  in  BITS  lane 2 symbol
LANE3  in  BITS  lane 3 symbol
LANE_DK  in  4  K flag per lane; bit i belongs to LANEi
IN_VALID  in  1  lane word valid
IN_READY  out  1  block can take a word; depends on state only
D  out  BITS  serialised byte
o_DK  out  1  K flag of D
OUT_VALID  out  1  D/o_DK valid
PKT_ACTIVE  out  1  byte on D belongs to a packet, STP/SDP through END/EDB inclusive
FRAME_ERR  out  1  one-cycle pulse aligned with the offending byte

Behaviour:
- Reset: while RESET=1, at every edge clear all state. D=0, o_DK=0, OUT_VALID=0, PKT_ACTIVE=0, FRAME_ERR=0, both slots empty, IDX=0, FSM=IDLE. IN_READY=0 while RESET=1.
- Reset mid-word: any partial word is discarded. Remaining lanes are never emitted.
- Storage: two word slots.
  - SER: the word being serialised, plus lane index IDX (2 bits).
  - HOLD: one pending word.
- IN_READY = !HOLD_VALID && !RESET.
- Accept: a word is accepted when IN_VALID && IN_READY at a posedge.
  - It goes straight to SER if SER is empty, or if SER is emitting lane 3 this edge and HOLD is empty.
  - Otherwise it goes to HOLD.
- Serialise: when SER is valid, each edge does the following.
  - D <= SER lane[IDX], o_DK <= LANE_DK[IDX], OUT_VALID <= 1, IDX <= IDX+1 (wraps 3 to 0).
  - When IDX=3: SER <= HOLD if HOLD is valid (HOLD is emptied), else the word accepted this edge, else SER becomes empty.
  - When SER is empty: OUT_VALID <= 0. D and o_DK hold their last value.
- Latency and throughput:
  - Word accepted at edge N into an empty SER: lane0 is visible after edge N+1, lane3 after edge N+4.
  - Sustained rate is one word per 4 cycles with no OUT_VALID bubbles between words.
- Symbol constants (K=1 only): STP=FB, SDP=5C, END=FD, EDB=FE, COM=BC, SKP=1C, IDL=7C. All bytes pass through unchanged; nothing is dropped.
- Framing FSM: evaluated on each byte as it is loaded into D. PKT_ACTIVE and FRAME_ERR are registered alongside D.
  - IDLE, K STP/SDP on lane 0: go to INPKT; PKT_ACTIVE=1 on that byte.
  - IDLE, K STP/SDP on lanes 1-3: FRAME_ERR; stay IDLE.
  - IDLE, K END/EDB: FRAME_ERR; stay IDLE.
  - INPKT, K END/EDB on lane 3: PKT_ACTIVE=1 on that byte; go to IDLE.
  - INPKT, K END/EDB on lanes 0-2: FRAME_ERR; PKT_ACTIVE=1 on that byte; go to IDLE.
  - INPKT, K STP/SDP on lane 0: FRAME_ERR; stay INPKT (packet restarts).
  - INPKT, K STP/SDP on lanes 1-3: FRAME_ERR; go to IDLE.
  - Any other byte: no state change. PKT_ACTIVE = (state==INPKT).
  - A simultaneous error and transition applies both within the same cycle.
  - When OUT_VALID=0: PKT_ACTIVE and FRAME_ERR are 0, and the FSM holds.

Decomposition:
- Shared package/include with:
  - the K-symbol constants (STP, SDP, END, EDB, COM, SKP, IDL), shared with the transmit striper;
  - the framing FSM state encoding (IDLE, INPKT).
- One sub-module, unstrip_frame_chk: the framing FSM plus PKT_ACTIVE/FRAME_ERR registers, fed with byte, K flag, lane index and valid.

Test Plan:
- Single word after reset, lanes {FB(K),11,22,33}, accepted at edge N -> D = FB,11,22,33 after edges N+1..N+4; o_DK = 1,0,0,0; OUT_VALID high for exactly 4 cycles; PKT_ACTIVE = 1 on all four; FRAME_ERR = 0.
- Three back-to-back words with IN_VALID held high -> OUT_VALID high for 12 contiguous cycles; bytes in exact lane order; IN_READY drops to 0 only while HOLD is full; no word lost or duplicated.
- Packet close, {FB(K),01,02,03} then {AA,BB,CC,FD(K)} -> PKT_ACTIVE high through the FD byte and 0 on the next byte; FRAME_ERR never set.
- Misplaced END, in packet, word {10,FD(K),12,13} -> FRAME_ERR pulses only on the FD byte; PKT_ACTIVE=0 from byte 12 onward.
- STP on lane 2 while IDLE -> FRAME_ERR pulse on that byte; PKT_ACTIVE stays 0.
- RESET for one cycle after lane1 is emitted -> next cycle OUT_VALID=0 and D=0; lanes 2 and 3 never appear; IN_READY=0 during reset and 1 on the following cycle.
